// File: rtl/metadata_responder.sv
// Purpose: serves per-channel 16-bit note metadata slots, refilling each slot from the note RAM on consumer request.
// Latency: request edge E -> rd_en in cycle after E+1 -> slot and available updated at edge E+2+RD_LAT.
// Backpressure: one RAM read in flight; pending refills wait their round-robin turn (worst case NCH*(RD_LAT+2) cycles).
//
// Ports:
//   clk, reset (async, active low), rewind (restart all channels from word 0)
//   metadata_request[NCH]  : per-channel pulse, consumer took slot i
//   metadata_available[NCH], metadata_link[NCH*16], done[NCH] : registered slot state
//   rd_en, rd_addr {channel, word}, rd_data (valid RD_LAT cycles after rd_en)
//   underrun_count : requests against empty slots; live only with METADATA_UNDERRUN_CNT_EN defined
module metadata_responder #(
    parameter int NCH     = 37,
    parameter int CH_BITS = 6,
    parameter int CH_AW   = 10,
    parameter int RD_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rewind,
    input  logic [NCH-1:0]             metadata_request,
    output logic [NCH-1:0]             metadata_available,
    output logic [NCH*16-1:0]          metadata_link,
    output logic [NCH-1:0]             done,
    output logic                       rd_en,
    output logic [CH_BITS+CH_AW-1:0]   rd_addr,
    input  logic [15:0]                rd_data,
    output logic [15:0]                underrun_count
);

    localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CW-1:0]      LAT_LAST = CW'(RD_LAT);
    localparam logic [CH_BITS-1:0] LAST_CH  = CH_BITS'(NCH - 1);
    localparam logic [CH_BITS:0]   NCH_W    = (CH_BITS + 1)'(NCH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CH_BITS-1:0]   chan;
    logic [CH_BITS-1:0]   rr;
    logic [CH_BITS-1:0]   sel_chan;
    logic [CH_BITS-1:0]   sel_off;
    logic [CH_BITS:0]     sel_sum;
    logic                 sel_found;
    logic [2*NCH-1:0]     pend_dbl;
    logic [NCH-1:0]       pend_rot;
    logic [CW-1:0]        wait_cnt;
    logic                 capture;

    logic [CH_AW-1:0]     ptr  [NCH];
    logic [15:0]          slot [NCH];
    logic [NCH-1:0]       pending;
    logic [NCH-1:0]       available;

    // Round-robin pick: rotate pending so the RR pointer sits at bit 0,
    // take the lowest set bit, then map the offset back to a channel.
    always_comb begin
        pend_dbl  = {pending, pending} >> rr;
        pend_rot  = pend_dbl[NCH-1:0];
        sel_off   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (pend_rot[k]) begin
                sel_off = CH_BITS'(k);
            end
        end
        sel_found = |pending;
        sel_sum   = {1'b0, rr} + {1'b0, sel_off};
        if (sel_sum >= NCH_W) begin
            sel_sum = sel_sum - NCH_W;
        end
        sel_chan  = sel_sum[CH_BITS-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_cnt == LAT_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A rewind abandons whatever read is in flight.
        if (rewind) begin
            state_nxt = IDLE;
        end
    end

    assign capture = (state == WAIT) && (wait_cnt == LAT_LAST) && !rewind;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chan     <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == IDLE && sel_found) begin
                chan <= sel_chan;
            end
            if (state == ISSUE) begin
                wait_cnt <= CW'(1);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '1;
            available <= '0;
            done      <= '0;
            rr        <= '0;
            for (int i = 0; i < NCH; i++) begin
                ptr[i]  <= '0;
                slot[i] <= '0;
            end
        end else if (rewind) begin
            // Slots keep their last contents; only the bookkeeping restarts.
            pending   <= '1;
            available <= '0;
            done      <= '0;
            rr        <= '0;
            for (int i = 0; i < NCH; i++) begin
                ptr[i] <= '0;
            end
        end else begin
            // Requests on done channels are ignored; requests on empty slots are
            // protocol violations and change nothing here.
            for (int i = 0; i < NCH; i++) begin
                if (metadata_request[i] && available[i] && !done[i]) begin
                    available[i] <= 1'b0;
                    pending[i]   <= 1'b1;
                end
            end
            // The captured channel is pending, hence not available, so a request
            // in the same cycle can never touch the same bit.
            if (capture) begin
                slot[chan]      <= rd_data;
                available[chan] <= 1'b1;
                pending[chan]   <= 1'b0;
                rr              <= (chan == LAST_CH) ? '0 : chan + 1'b1;
                if (rd_data == 16'hFFFF) begin
                    done[chan] <= 1'b1;
                end else if (&ptr[chan]) begin
                    // Last word of the region: keep the data, stop refilling.
                    done[chan] <= 1'b1;
                end else begin
                    ptr[chan] <= ptr[chan] + 1'b1;
                end
            end
        end
    end

    assign rd_en   = (state == ISSUE);
    assign rd_addr = rd_en ? {chan, ptr[chan]} : '0;

    assign metadata_available = available;

    for (genvar g = 0; g < NCH; g++) begin : g_link
        assign metadata_link[16*g +: 16] = slot[g];
    end

`ifdef METADATA_UNDERRUN_CNT_EN
    logic underrun_hit;

    // Any number of offending bits in one cycle counts once.
    assign underrun_hit = |(metadata_request & ~available & ~done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_count <= '0;
        end else if (!rewind && underrun_hit && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 1'b1;
        end
    end
`else
    assign underrun_count = '0;
`endif

endmodule
